// File: rtl/gb_pix_streamer.sv
// gb_pix_streamer: streams one raster-order grayscale frame from a linear
// 8-bit pixel memory onto the blur accelerator input stream (arg_1_*).
//
// Ports:
//   clk, rst_n          clock, async active-low reset
//   start               one-cycle frame request, honoured only when idle
//   mem_rd_en/mem_addr  read strobe and linear address (y*IMG_W + x)
//   mem_rd_data         read data, valid one cycle after mem_rd_en
//   arg_1_TDATA/TVALID  pixel out, held stable until TREADY accepts it
//   arg_1_TREADY        accelerator ready (backpressure)
//   busy, done          frame in progress / one-cycle end-of-frame pulse
//   pix_x, pix_y        coordinates of the pixel currently on TDATA
module gb_pix_streamer #(
   parameter int IMG_W = 648,
   parameter int IMG_H = 488,
   parameter int AW    = 19
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   output logic          mem_rd_en,
   output logic [AW-1:0] mem_addr,
   input  logic [7:0]    mem_rd_data,
   output logic [7:0]    arg_1_TDATA,
   output logic          arg_1_TVALID,
   input  logic          arg_1_TREADY,
   output logic          busy,
   output logic          done,
   output logic [9:0]    pix_x,
   output logic [9:0]    pix_y
);

   localparam logic [AW-1:0] LAST_ADDR = AW'(IMG_W * IMG_H - 1);
   localparam logic [9:0]    LAST_X    = 10'(IMG_W - 1);
   localparam logic [9:0]    LAST_Y    = 10'(IMG_H - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DRAIN,
      S_DONE
   } state_t;

   state_t        r_state;
   logic [AW-1:0] r_rd_cnt;
   logic [AW-1:0] r_addr;
   logic          r_infl;
   logic          r_tvalid;
   logic [7:0]    r_tdata;
   logic          r_sp_vld;
   logic [7:0]    r_sp_data;
   logic          r_busy;
   logic          r_done;
   logic [9:0]    r_x;
   logic [9:0]    r_y;

   logic          w_pop;
   logic [1:0]    w_fill;
   logic          w_rd;
   logic          w_last_px;

   assign w_pop     = r_tvalid & arg_1_TREADY;
   assign w_fill    = {1'b0, r_tvalid} + {1'b0, r_sp_vld} + {1'b0, r_infl};
   // A slot freed by this cycle's transfer can be refilled by a read issued
   // in the same cycle, which is what sustains one pixel per cycle.
   assign w_rd      = (r_state == S_RUN) &&
                      ((w_fill - {1'b0, w_pop}) < 2'd2);
   assign w_last_px = (r_x == LAST_X) && (r_y == LAST_Y);

   assign mem_rd_en    = w_rd;
   assign mem_addr     = w_rd ? r_rd_cnt : r_addr;
   assign arg_1_TDATA  = r_tdata;
   assign arg_1_TVALID = r_tvalid;
   assign busy         = r_busy;
   assign done         = r_done;
   assign pix_x        = r_x;
   assign pix_y        = r_y;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= S_IDLE;
         r_rd_cnt  <= '0;
         r_addr    <= '0;
         r_infl    <= 1'b0;
         r_tvalid  <= 1'b0;
         r_tdata   <= '0;
         r_sp_vld  <= 1'b0;
         r_sp_data <= '0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_x       <= '0;
         r_y       <= '0;
      end else begin
         r_infl <= w_rd;

         if (w_rd) begin
            r_addr   <= r_rd_cnt;
            r_rd_cnt <= (r_rd_cnt == LAST_ADDR) ? '0 : r_rd_cnt + AW'(1);
         end

         // Skid buffer: the output register is refilled from the spare
         // first (older pixel), then from the returning read.
         if (!r_tvalid || w_pop) begin
            if (r_sp_vld) begin
               r_tvalid <= 1'b1;
               r_tdata  <= r_sp_data;
               r_sp_vld <= r_infl;
               if (r_infl) begin
                  r_sp_data <= mem_rd_data;
               end
            end else if (r_infl) begin
               r_tvalid <= 1'b1;
               r_tdata  <= mem_rd_data;
            end else begin
               r_tvalid <= 1'b0;
            end
         end else if (r_infl) begin
            r_sp_vld  <= 1'b1;
            r_sp_data <= mem_rd_data;
         end

         if (w_pop) begin
            if (r_x == LAST_X) begin
               r_x <= '0;
               r_y <= (r_y == LAST_Y) ? '0 : r_y + 10'd1;
            end else begin
               r_x <= r_x + 10'd1;
            end
         end

         r_done <= 1'b0;
         unique case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_state <= S_RUN;
                  r_busy  <= 1'b1;
               end
            end
            S_RUN: begin
               if (w_rd && (r_rd_cnt == LAST_ADDR)) begin
                  r_state <= S_DRAIN;
               end
            end
            S_DRAIN: begin
               if (w_pop && w_last_px) begin
                  r_state <= S_DONE;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
               end
            end
            S_DONE: begin
               r_state <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_gb_pix_streamer.sv
// tb_gb_pix_streamer: scenario bench for gb_pix_streamer on a 4x3 frame.
// Expected pixels come from the bench memory model in raster order.
module tb_gb_pix_streamer;

   localparam int W  = 4;
   localparam int H  = 3;
   localparam int N  = W * H;
   localparam int AW = 4;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic          mem_rd_en;
   logic [AW-1:0] mem_addr;
   logic [7:0]    mem_rd_data = 8'd0;
   logic [7:0]    arg_1_TDATA;
   logic          arg_1_TVALID;
   logic          arg_1_TREADY = 1'b0;
   logic          busy;
   logic          done;
   logic [9:0]    pix_x;
   logic [9:0]    pix_y;

   int n_chk = 0;
   int n_err = 0;

   logic [7:0] mem [0:(1<<AW)-1];

   gb_pix_streamer #(
      .IMG_W(W),
      .IMG_H(H),
      .AW(AW)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .start(start),
      .mem_rd_en(mem_rd_en),
      .mem_addr(mem_addr),
      .mem_rd_data(mem_rd_data),
      .arg_1_TDATA(arg_1_TDATA),
      .arg_1_TVALID(arg_1_TVALID),
      .arg_1_TREADY(arg_1_TREADY),
      .busy(busy),
      .done(done),
      .pix_x(pix_x),
      .pix_y(pix_y)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (mem_rd_en) mem_rd_data <= mem[mem_addr];
   end

   function automatic logic rdy(input int mode, input int c);
      case (mode)
         1:       return !(c >= 3 && c <= 10);
         2:       return (c % 2) == 1;
         3:       return $urandom_range(0, 1) == 1;
         default: return 1'b1;
      endcase
   endfunction

   task automatic fill(input bit inc);
      for (int i = 0; i < (1 << AW); i++)
         mem[i] = inc ? 8'(i) : 8'($urandom_range(0, 255));
   endtask

   // mode 0: ready high, 1: stall cycles 3-10, 2: alternate,
   // 3: random ready, 4: ready high with stray start pulses
   task automatic stream_frame(input int mode, input int abort_at,
                               output int ntx);
      int issued = 0;
      int last = -100;
      int c = 0;
      logic pv = 1'b0;
      logic pr = 1'b0;
      logic [7:0] pd = 8'd0;
      bit fin = 1'b0;
      logic eb;
      ntx = 0;
      while (!fin) begin
         @(negedge clk);
         start = (c == 0) ||
                 (mode == 4 && (c == 5 || c == 8 || c == last + 1));
         arg_1_TREADY = rdy(mode, c);
         #1;
         if (c == 0) begin
            n_chk++;
            if (busy !== 1'b0 || mem_rd_en !== 1'b0 || arg_1_TVALID !== 1'b0) begin
               n_err++;
               $display("FAIL idle_before_start busy=%b rd=%b tv=%b required 0 0 0",
                        busy, mem_rd_en, arg_1_TVALID);
            end
         end
         if (c == 1) begin
            n_chk++;
            if (mem_rd_en !== 1'b1 || mem_addr !== '0) begin
               n_err++;
               $display("FAIL first_read rd=%b addr=%0d required 1 0",
                        mem_rd_en, mem_addr);
            end
         end
         if (c <= 3) begin
            n_chk++;
            if (arg_1_TVALID !== (c == 3)) begin
               n_err++;
               $display("FAIL tvalid_latency c=%0d tv=%b required %b",
                        c, arg_1_TVALID, c == 3);
            end
         end
         if (pv && !pr) begin
            n_chk++;
            if (arg_1_TVALID !== 1'b1 || arg_1_TDATA !== pd) begin
               n_err++;
               $display("FAIL hold c=%0d tv=%b data=%0d required 1 %0d",
                        c, arg_1_TVALID, arg_1_TDATA, pd);
            end
         end
         n_chk++;
         if (issued - ntx > 2) begin
            n_err++;
            $display("FAIL occupancy c=%0d outstanding=%0d required <=2",
                     c, issued - ntx);
         end
         if (mem_rd_en === 1'b1) begin
            n_chk++;
            if (mem_addr !== AW'(issued) || issued >= N) begin
               n_err++;
               $display("FAIL read_addr c=%0d addr=%0d required %0d (<%0d)",
                        c, mem_addr, issued, N);
            end
            issued++;
         end
         eb = (c >= 1) && (last < 0 || c <= last);
         n_chk++;
         if (busy !== eb || done !== (c == last + 1)) begin
            n_err++;
            $display("FAIL busy_done c=%0d busy=%b done=%b required %b %b",
                     c, busy, done, eb, c == last + 1);
         end
         if (arg_1_TVALID === 1'b1 && arg_1_TREADY) begin
            n_chk++;
            if (ntx >= N || arg_1_TDATA !== mem[ntx] ||
                pix_x !== 10'(ntx % W) || pix_y !== 10'(ntx / W)) begin
               n_err++;
               $display("FAIL pixel k=%0d data=%0d x=%0d y=%0d required %0d %0d %0d",
                        ntx, arg_1_TDATA, pix_x, pix_y,
                        mem[ntx % N], ntx % W, ntx / W);
            end
            ntx++;
            if (ntx == N) last = c;
         end
         pv = arg_1_TVALID;
         pd = arg_1_TDATA;
         pr = arg_1_TREADY;
         if (abort_at > 0 && ntx == abort_at) fin = 1'b1;
         else if (last >= 0 && c == ((mode == 4) ? last + 1 : last + 2))
            fin = 1'b1;
         else if (c >= 200) begin
            n_err++;
            $display("FAIL timeout c=%0d transfers=%0d required %0d",
                     c, ntx, N);
            fin = 1'b1;
         end
         c++;
      end
      start = 1'b0;
   endtask

   task automatic test_reset();
      @(negedge clk);
      n_chk++;
      if (arg_1_TVALID !== 1'b0 || busy !== 1'b0 || done !== 1'b0 ||
          mem_rd_en !== 1'b0 || mem_addr !== '0 || arg_1_TDATA !== 8'd0 ||
          pix_x !== 10'd0 || pix_y !== 10'd0) begin
         n_err++;
         $display("FAIL reset_state tv=%b busy=%b done=%b rd=%b addr=%0d data=%0d x=%0d y=%0d required all 0",
                  arg_1_TVALID, busy, done, mem_rd_en, mem_addr,
                  arg_1_TDATA, pix_x, pix_y);
      end
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      n_chk++;
      if (busy !== 1'b0 || mem_rd_en !== 1'b0 || arg_1_TVALID !== 1'b0) begin
         n_err++;
         $display("FAIL idle_after_reset busy=%b rd=%b tv=%b required 0 0 0",
                  busy, mem_rd_en, arg_1_TVALID);
      end
   endtask

   task automatic test_basic();
      int n;
      fill(1'b1);
      stream_frame(0, 0, n);
      n_chk++;
      if (n !== N) begin
         n_err++;
         $display("FAIL basic_count got=%0d required %0d", n, N);
      end
   endtask

   task automatic test_stall();
      int n;
      fill(1'b0);
      stream_frame(1, 0, n);
      n_chk++;
      if (n !== N) begin
         n_err++;
         $display("FAIL stall_count got=%0d required %0d", n, N);
      end
   endtask

   task automatic test_toggle();
      int n;
      fill(1'b0);
      stream_frame(2, 0, n);
      n_chk++;
      if (n !== N) begin
         n_err++;
         $display("FAIL toggle_count got=%0d required %0d", n, N);
      end
   endtask

   task automatic test_back_to_back();
      int n1;
      int n2;
      fill(1'b1);
      stream_frame(4, 0, n1);
      stream_frame(0, 0, n2);
      n_chk++;
      if (n1 !== N || n2 !== N) begin
         n_err++;
         $display("FAIL back_to_back got=%0d,%0d required %0d,%0d",
                  n1, n2, N, N);
      end
   endtask

   task automatic test_random();
      int n;
      for (int f = 0; f < 4; f++) begin
         fill(1'b0);
         stream_frame(3, 0, n);
         n_chk++;
         if (n !== N) begin
            n_err++;
            $display("FAIL random_count frame=%0d got=%0d required %0d",
                     f, n, N);
         end
      end
   endtask

   task automatic test_reset_mid();
      int n;
      fill(1'b1);
      stream_frame(0, 6, n);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      n_chk++;
      if (arg_1_TVALID !== 1'b0 || busy !== 1'b0 || pix_x !== 10'd0 ||
          pix_y !== 10'd0 || done !== 1'b0) begin
         n_err++;
         $display("FAIL reset_mid tv=%b busy=%b x=%0d y=%0d done=%b required all 0",
                  arg_1_TVALID, busy, pix_x, pix_y, done);
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         n_chk++;
         if (done !== 1'b0 || busy !== 1'b0 || mem_rd_en !== 1'b0) begin
            n_err++;
            $display("FAIL after_abort i=%0d done=%b busy=%b rd=%b required 0 0 0",
                     i, done, busy, mem_rd_en);
         end
      end
      stream_frame(0, 0, n);
      n_chk++;
      if (n !== N) begin
         n_err++;
         $display("FAIL restart_count got=%0d required %0d", n, N);
      end
   endtask

   initial begin
      fill(1'b1);
      repeat (3) @(negedge clk);
      test_reset();
      test_basic();
      test_stall();
      test_toggle();
      test_back_to_back();
      test_random();
      test_reset_mid();
      repeat (3) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
